multicycle_memory: RTL

MULTICYCLE_MEMORY -- requirements
Module: multicycle_memory

---
 rtl/multicycle_memory.sv | 95 +++++++++
 1 files changed

// File: rtl/multicycle_memory.sv
// rtl/multicycle_memory.sv - fixed-latency word memory with IDLE/WAIT/RESP request handshake
module multicycle_memory #(
  parameter int ADDR_W  = 10,
  parameter int LATENCY = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        wr,
  input  logic [15:0] addr,
  input  logic [15:0] data_in,
  output logic [15:0] data_out,
  output logic        data_valid,
  output logic        busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic [3:0]          r_cnt;
  logic                r_wr;
  logic [15:0]         r_addr;
  logic [15:0]         r_data;
  logic [15:0]         r_dout;
  logic [15:0]         r_mem [2**ADDR_W];

  logic                w_accept;
  logic                w_done;
  logic [ADDR_W-1:0]   w_index;
  logic                w_unused_addr;

  assign w_accept = (r_state == S_IDLE) && enable;
  assign w_done   = (r_state == S_WAIT) && (r_cnt == 4'd0);
  // Byte address to word index; byte lane and high bits alias away.
  assign w_index  = r_addr[ADDR_W:1];
  assign w_unused_addr = ^{r_addr[15:ADDR_W+1], r_addr[0]};

  assign busy       = (r_state != S_IDLE);
  assign data_valid = (r_state == S_RESP);
  assign data_out   = r_dout;

  // State register; reset wins over everything, aborting any transaction.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next-state logic for the request handshake.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (enable) w_next = S_WAIT;
      S_WAIT:  if (r_cnt == 4'd0) w_next = S_RESP;
      S_RESP:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Latency down-counter: loaded on acceptance, counts through WAIT.
  always_ff @(posedge clk) begin
    if (rst)                                      r_cnt <= 4'd0;
    else if (w_accept)                            r_cnt <= 4'(LATENCY - 2);
    else if (r_state == S_WAIT && r_cnt != 4'd0)  r_cnt <= r_cnt - 4'd1;
  end

  // Request capture; inputs are frozen out while a transaction is in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr   <= 1'b0;
      r_addr <= 16'h0000;
      r_data <= 16'h0000;
    end else if (w_accept) begin
      r_wr   <= wr;
      r_addr <= addr;
      r_data <= data_in;
    end
  end

  // Response data: array word for reads, zero acknowledge for writes, held otherwise.
  always_ff @(posedge clk) begin
    if (rst)         r_dout <= 16'h0000;
    else if (w_done) r_dout <= r_wr ? 16'h0000 : r_mem[w_index];
  end

  // Array write happens only on the WAIT->RESP edge; contents survive reset.
  always_ff @(posedge clk) begin
    if (!rst && w_done && r_wr) r_mem[w_index] <= r_data;
  end

endmodule
